btn_debounce_multi: RTL and testbench

Parametrised N-channel push-button conditioner. It is the front end between the board's raw button and switch pins and the game/control FSMs. Per channel it provides:
- polarity normalisation and two-stage synchronisation;
- counter-based debounce producing a stable level;
- single-cycle press and release pulses;
- a long-press pulse, followed by periodic auto-repeat pulses while the button stays held.

---
 rtl/btn_debounce_multi.sv | 130 +++++++++++++
 tb/tb_btn_debounce_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: polarity fix, 2-flop sync, counter debounce,
// press/release pulses, long-press pulse and auto-repeat while held.
module btn_debounce_multi #(
  parameter int              N_CH       = 5,
  parameter int              CNT_MAX    = 2_000_000,
  parameter int              LONG_CYC   = 100_000_000,
  parameter int              REPEAT_CYC = 20_000_000,
  parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } hold_st_e;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          sync0_q, sync1_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, repeat_q;
    logic [HW-1:0] hcnt_q;
    hold_st_e      state_q;

    // A new level is accepted only after CNT_MAX consecutive disagreeing cycles.
    always_comb begin
      stable_d  = stable_q;
      dcnt_d    = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync1_q != stable_q) begin
        if (dcnt_q == CNT_LAST) begin
          stable_d  = sync1_q;
          press_d   = sync1_q;
          release_d = ~sync1_q;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync0_q   <= 1'b0;
        sync1_q   <= 1'b0;
        stable_q  <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        hcnt_q    <= '0;
        state_q   <= ST_IDLE;
      end else begin
        sync0_q   <= btn_in[gi] ^ ACTIVE_LOW[gi];
        sync1_q   <= sync0_q;
        stable_q  <= stable_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        // An accepted release wins over any long/repeat due on the same edge.
        if (release_d) begin
          state_q <= ST_IDLE;
          hcnt_q  <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (press_d) begin
                state_q <= ST_HOLD;
                hcnt_q  <= '0;
              end
            end
            ST_HOLD: begin
              if (hcnt_q == LONG_LAST) begin
                long_q  <= 1'b1;
                hcnt_q  <= '0;
                state_q <= ST_REPEAT;
              end else begin
                hcnt_q <= hcnt_q + HW'(1);
              end
            end
            ST_REPEAT: begin
              // With repeat disabled the channel parks here with the counter frozen.
              if (REPEAT_CYC != 0) begin
                if (hcnt_q == REP_LAST) begin
                  repeat_q <= 1'b1;
                  hcnt_q   <= '0;
                end else begin
                  hcnt_q <= hcnt_q + HW'(1);
                end
              end
            end
            default: begin
              state_q <= ST_IDLE;
              hcnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[gi]   = stable_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_long[gi]    = long_q;
    assign btn_repeat[gi]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: per-cycle vector table for reset/debounce,
// then event-timing sequences for long press, repeat, polarity and mid-hold reset.
module tb_btn_debounce_multi;

  localparam int N_CH = 2;
  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  int n_tests = 0;
  int n_fail  = 0;

  btn_debounce_multi #(
    .N_CH(N_CH), .CNT_MAX(4), .LONG_CYC(10), .REPEAT_CYC(3), .ACTIVE_LOW(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t vecs[$];
  int   act0[$], act1[$], exp0[$], exp1[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input int n, input logic r, input logic [1:0] b,
                     input logic [1:0] l, input logic [1:0] p, input logic [1:0] rl);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = l; v.prs = p; v.rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drive pin masks (bit t = pin value before tick t), log every pulse as tick*4+kind.
  task automatic watch(input string name, input int n, input logic [63:0] pin0,
                       input logic [63:0] pin1, input int rst_tick);
    int multi = 0;
    act0.delete();
    act1.delete();
    for (int t = 1; t <= n; t++) begin
      rst_n  = (t == rst_tick) ? 1'b0 : 1'b1;
      btn_in = {pin1[t], pin0[t]};
      tick();
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [3:0] ev;
        ev = {btn_repeat[ch], btn_long[ch], btn_release[ch], btn_press[ch]};
        if ($countones(ev) > 1) multi++;
        for (int k = 0; k < 4; k++) begin
          if (ev[k]) begin
            $display("[TB] %s tick %0d ch%0d pulse kind %0d", name, t, ch, k);
            if (ch == 0) act0.push_back(t * 4 + k);
            else         act1.push_back(t * 4 + k);
          end
        end
      end
      if (t == rst_tick) begin
        n_tests++;
        if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} != '0) begin
          n_fail++;
          $display("FAIL %s reset_outputs: got %b want 0", name,
                   {btn_level, btn_press, btn_release, btn_long, btn_repeat});
        end
      end
    end
    n_tests++;
    if (multi != 0) begin
      n_fail++;
      $display("FAIL %s onehot: got %0d multi-pulse cycles want 0", name, multi);
    end
  endtask

  task automatic check_events(input string name);
    int e[$], a[$];
    for (int ch = 0; ch < N_CH; ch++) begin
      if (ch == 0) begin e = exp0; a = act0; end
      else         begin e = exp1; a = act1; end
      n_tests++;
      if (a.size() != e.size()) begin
        n_fail++;
        $display("FAIL %s ch%0d event_count: got %0d want %0d", name, ch, a.size(), e.size());
      end
      for (int i = 0; i < e.size(); i++) begin
        int got;
        got = (i < a.size()) ? a[i] : -1;
        n_tests++;
        if (got != e[i]) begin
          n_fail++;
          $display("FAIL %s ch%0d event%0d: got tick %0d kind %0d want tick %0d kind %0d",
                   name, ch, i, got / 4, got % 4, e[i] / 4, e[i] % 4);
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 2'b11;

    // rst btn lvl prs rel (long/repeat expected 0 throughout)
    add(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);  // reset held
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);  // ticks 1-5: qualifying
    add(1, 1'b1, 2'b11, 2'b01, 2'b01, 2'b00);  // tick 6: ch0 press
    add(5, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00);  // ticks 7-11
    add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01);  // tick 12: release
    add(3, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);  // 3-cycle glitch
    add(4, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    add(4, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);  // 4-cycle pulse
    add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b00);  // tick 25: press
    add(3, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
    add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01);  // tick 29: release
    add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [9:0] got, want;
      rst_n  = vecs[i].rst;
      btn_in = vecs[i].btn;
      tick();
      got  = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
      want = {vecs[i].lvl, vecs[i].prs, vecs[i].rel, 4'b0000};
      n_tests++;
      $display("[TB] vec %0d rst_n=%b btn=%b out=%b", i, vecs[i].rst, vecs[i].btn, got);
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec%0d lvl/prs/rel/long/rep: got %b want %b", i, got, want);
      end
    end

    // Long press with repeats; repeat due at tick 46 is displaced by the release.
    watch("long_repeat", 55, rng(1, 40), '1, 0);
    exp0 = '{6*4+K_PRESS, 16*4+K_LONG, 19*4+K_REP, 22*4+K_REP, 25*4+K_REP, 28*4+K_REP,
             31*4+K_REP, 34*4+K_REP, 37*4+K_REP, 40*4+K_REP, 43*4+K_REP, 46*4+K_REL};
    exp1 = {};
    check_events("long_repeat");
    n_tests++;
    if (btn_level !== 2'b00) begin
      n_fail++;
      $display("FAIL long_repeat final_level: got %b want 00", btn_level);
    end

    // Release during HOLD, then immediate re-press restarts the hold count.
    watch("hold_release", 40, rng(1, 7) | rng(14, 29), '1, 0);
    exp0 = '{6*4+K_PRESS, 13*4+K_REL, 19*4+K_PRESS, 29*4+K_LONG, 32*4+K_REP, 35*4+K_REL};
    exp1 = {};
    check_events("hold_release");

    // ch1 active-low held while ch0 toggles and glitches; same-cycle press on both.
    watch("polarity", 55, rng(1, 7) | rng(20, 21), ~rng(1, 40), 0);
    exp0 = '{6*4+K_PRESS, 13*4+K_REL};
    exp1 = '{6*4+K_PRESS, 16*4+K_LONG, 19*4+K_REP, 22*4+K_REP, 25*4+K_REP, 28*4+K_REP,
             31*4+K_REP, 34*4+K_REP, 37*4+K_REP, 40*4+K_REP, 43*4+K_REP, 46*4+K_REL};
    check_events("polarity");

    // One-cycle reset in REPEAT while held: fresh press 5 ticks after deassertion.
    watch("reset_repeat", 40, rng(1, 40), '1, 21);
    exp0 = '{6*4+K_PRESS, 16*4+K_LONG, 19*4+K_REP, 27*4+K_PRESS, 37*4+K_LONG, 40*4+K_REP};
    exp1 = {};
    check_events("reset_repeat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
